exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_stage.sv | 157 +++++++++++++++
 tb/tb_exec_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// exec_stage: multi-cycle execute unit for a small load/store datapath.
// Reads A then B from the register file, shifts B, runs the ALU, writes C back.
module exec_stage #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   rn,
   input  logic [2:0]   rm,
   input  logic [2:0]   rd,
   input  logic [1:0]   aluop,
   input  logic [1:0]   shift,
   input  logic [W-1:0] rf_data,
   output logic [2:0]   readnum,
   output logic [2:0]   writenum,
   output logic         write,
   output logic [W-1:0] wb_data,
   output logic [2:0]   status,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RDA  = 3'd1,
      RDB  = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   state_t       state;
   logic [2:0]   rn_q;
   logic [2:0]   rm_q;
   logic [2:0]   rd_q;
   logic [1:0]   op_q;
   logic [1:0]   sh_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [W-1:0] c_q;
   logic [W-1:0] bsh;
   logic [W-1:0] res;
   logic         ovf;

   // Barrel stage: single-position shift of B ahead of the ALU
   always_comb begin
      bsh = b_q;
      unique case (sh_q)
         SH_NONE: bsh = b_q;
         SH_LSL:  bsh = {b_q[W-2:0], 1'b0};
         SH_LSR:  bsh = {1'b0, b_q[W-1:1]};
         SH_ASR:  bsh = {b_q[W-1], b_q[W-1:1]};
         default: bsh = b_q;
      endcase
   end

   // ALU result and signed overflow; overflow only meaningful for add/sub
   always_comb begin
      res = '0;
      ovf = 1'b0;
      unique case (op_q)
         OP_ADD: begin
            res = a_q + bsh;
            ovf = (a_q[W-1] == bsh[W-1]) && (res[W-1] != a_q[W-1]);
         end
         OP_SUB: begin
            res = a_q - bsh;
            ovf = (a_q[W-1] != bsh[W-1]) && (res[W-1] != a_q[W-1]);
         end
         OP_AND: res = a_q & bsh;
         OP_NOT: res = ~bsh;
         default: res = '0;
      endcase
   end

   // Sequencer with all datapath registers and registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rn_q     <= '0;
         rm_q     <= '0;
         rd_q     <= '0;
         op_q     <= '0;
         sh_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status   <= '0;
         readnum  <= '0;
         writenum <= '0;
         write    <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  rn_q    <= rn;
                  rm_q    <= rm;
                  rd_q    <= rd;
                  op_q    <= aluop;
                  sh_q    <= shift;
                  readnum <= rn;
                  busy    <= 1'b1;
                  state   <= RDA;
               end
            end
            RDA: begin
               a_q     <= rf_data;
               readnum <= rm_q;
               state   <= RDB;
            end
            RDB: begin
               b_q     <= rf_data;
               readnum <= '0;
               state   <= EXEC;
            end
            EXEC: begin
               c_q      <= res;
               status   <= {ovf, res[W-1], (res == '0)};
               writenum <= rd_q;
               write    <= 1'b1;
               done     <= 1'b1;
               state    <= WB;
            end
            WB: begin
               writenum <= '0;
               write    <= 1'b0;
               done     <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               readnum  <= '0;
               writenum <= '0;
               write    <= 1'b0;
               done     <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign wb_data = c_q;

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed stimulus against a behavioural register file,
// with a scoreboard of expected writebacks checked as they appear.
module tb_exec_stage;

   localparam int W = 16;

   typedef struct {
      logic [2:0]   rd;
      logic [W-1:0] data;
      logic [2:0]   st;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [2:0]   rn, rm, rd;
   logic [1:0]   aluop, shift;
   logic [W-1:0] rf_data;
   logic [2:0]   readnum, writenum;
   logic         write;
   logic [W-1:0] wb_data;
   logic [2:0]   status;
   logic         busy, done;

   logic [W-1:0] rf [8];
   logic         pk_en = 1'b0;
   logic [2:0]   pk_a = '0;
   logic [W-1:0] pk_v = '0;

   exp_t sbq [$];
   int   cycle = 0;
   int   checks = 0;
   int   errors = 0;

   exec_stage #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rn(rn), .rm(rm), .rd(rd), .aluop(aluop), .shift(shift),
      .rf_data(rf_data), .readnum(readnum), .writenum(writenum),
      .write(write), .wb_data(wb_data), .status(status),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   assign rf_data = rf[readnum];

   // register file: DUT writeback plus bench preload port
   always @(posedge clk) begin
      if (write) rf[writenum] <= wb_data;
      if (pk_en) rf[pk_a] <= pk_v;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] n, m, d,
                                  input logic [1:0] op, sh);
      exp_t e;
      logic [W-1:0] a, b, r;
      logic signed [W:0] wide;
      logic v;
      a = rf[n];
      b = rf[m];
      case (sh)
         2'b01: b = b << 1;
         2'b10: b = b >> 1;
         2'b11: b = $unsigned($signed(b) >>> 1);
         default: ;
      endcase
      v = 1'b0;
      case (op)
         2'b00: begin
            wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
            r = wide[W-1:0];
            v = wide[W] ^ wide[W-1];
         end
         2'b01: begin
            wide = $signed({a[W-1], a}) - $signed({b[W-1], b});
            r = wide[W-1:0];
            v = wide[W] ^ wide[W-1];
         end
         2'b10: r = a & b;
         default: r = ~b;
      endcase
      e.rd = d;
      e.data = r;
      e.st = {v, r[W-1], r == '0};
      e.cyc = 0;
      return e;
   endfunction

   // writeback monitor: every write must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && write) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_write observed=%0d expected=none",
                   writenum);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("wb_writenum", 32'(writenum), 32'(e.rd));
            chk("wb_data", 32'(wb_data), 32'(e.data));
            chk("wb_status", 32'(status), 32'(e.st));
            chk("wb_latency", cycle, e.cyc);
            chk("wb_done", 32'(done), 32'd1);
         end
      end
   end

   task automatic set_reg(input logic [2:0] a, input logic [W-1:0] v);
      @(negedge clk);
      pk_en = 1'b1;
      pk_a = a;
      pk_v = v;
      @(negedge clk);
      pk_en = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic do_op(input logic [2:0] n, m, d,
                        input logic [1:0] op, sh, input bit poke);
      exp_t e;
      int t;
      wait_idle();
      e = model(n, m, d, op, sh);
      e.cyc = cycle + 4;
      sbq.push_back(e);
      rn = n; rm = m; rd = d; aluop = op; shift = sh;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rn = ~n; rm = ~m; rd = ~d; aluop = ~op; shift = ~sh;
      chk("busy_rda", 32'(busy), 32'd1);
      chk("readnum_a", 32'(readnum), 32'(n));
      @(negedge clk);
      chk("readnum_b", 32'(readnum), 32'(m));
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (sbq.size() != 0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("op_completed", sbq.size(), 0);
   endtask

   initial begin
      logic [W-1:0] keep;
      int c;
      exp_t e;
      for (int i = 0; i < 8; i++) rf[i] = '0;
      rst_n = 1'b0;
      start = 1'b0;
      rn = '0; rm = '0; rd = '0; aluop = '0; shift = '0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_readnum", 32'(readnum), 32'd0);
      chk("rst_writenum", 32'(writenum), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      set_reg(3'd1, 16'd5);
      set_reg(3'd2, 16'd3);
      do_op(3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b0);
      @(negedge clk);
      chk("add_r3", 32'(rf[3]), 32'd8);
      chk("add_status", 32'(status), 32'b000);

      set_reg(3'd1, 16'd3);
      do_op(3'd1, 3'd2, 3'd3, 2'b01, 2'b00, 1'b0);
      @(negedge clk);
      chk("sub_zero_r3", 32'(rf[3]), 32'd0);
      chk("sub_zero_status", 32'(status), 32'b001);

      set_reg(3'd1, 16'h8000);
      set_reg(3'd2, 16'h0001);
      do_op(3'd1, 3'd2, 3'd3, 2'b01, 2'b00, 1'b0);
      @(negedge clk);
      chk("sub_ovf_r3", 32'(rf[3]), 32'h7FFF);
      chk("sub_ovf_status", 32'(status), 32'b100);

      set_reg(3'd2, 16'h8001);
      do_op(3'd1, 3'd2, 3'd3, 2'b11, 2'b01, 1'b0);
      @(negedge clk);
      chk("not_lsl_r3", 32'(rf[3]), 32'hFFFD);
      chk("not_lsl_status", 32'(status), 32'b010);
      do_op(3'd1, 3'd2, 3'd3, 2'b11, 2'b10, 1'b1);
      @(negedge clk);
      chk("not_lsr_r3", 32'(rf[3]), 32'hBFFF);
      chk("not_lsr_status", 32'(status), 32'b010);
      do_op(3'd1, 3'd2, 3'd3, 2'b11, 2'b11, 1'b1);
      @(negedge clk);
      chk("not_asr_r3", 32'(rf[3]), 32'h3FFF);
      chk("not_asr_status", 32'(status), 32'b000);

      set_reg(3'd4, 16'h7FFF);
      set_reg(3'd5, 16'h0001);
      do_op(3'd4, 3'd5, 3'd6, 2'b00, 2'b00, 1'b0);
      @(negedge clk);
      chk("add_ovf_r6", 32'(rf[6]), 32'h8000);
      chk("add_ovf_status", 32'(status), 32'b110);
      set_reg(3'd4, 16'h1234);
      set_reg(3'd5, 16'hF0F0);
      do_op(3'd4, 3'd5, 3'd7, 2'b10, 2'b11, 1'b0);
      @(negedge clk);
      chk("and_asr_r7", 32'(rf[7]), 32'h1030);

      set_reg(3'd4, 16'h0101);
      set_reg(3'd5, 16'h0202);
      wait_idle();
      c = cycle;
      for (int i = 0; i < 3; i++) begin
         e = model(3'd4, 3'd5, 3'd6, 2'b00, 2'b00);
         e.cyc = c + 4 + 5 * i;
         sbq.push_back(e);
      end
      rn = 3'd4; rm = 3'd5; rd = 3'd6; aluop = 2'b00; shift = 2'b00;
      start = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         chk($sformatf("b2b_busy_%0d", i), 32'(busy),
             (i == 5 || i == 10) ? 32'd0 : 32'd1);
      end
      start = 1'b0;
      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
      repeat (8) @(negedge clk);
      chk("b2b_all_done", sbq.size(), 0);
      chk("b2b_r6", 32'(rf[6]), 32'h0303);

      wait_idle();
      keep = rf[3];
      rn = 3'd1; rm = 3'd2; rd = 3'd3; aluop = 2'b00; shift = 2'b00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_write", 32'(write), 32'd0);
      chk("abort_status", 32'(status), 32'b000);
      chk("abort_wb_data", 32'(wb_data), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_status_after", 32'(status), 32'b000);
      chk("abort_r3_kept", 32'(rf[3]), 32'(keep));
      set_reg(3'd1, 16'd7);
      set_reg(3'd2, 16'd2);
      do_op(3'd1, 3'd2, 3'd1, 2'b00, 2'b00, 1'b0);
      @(negedge clk);
      chk("rd_eq_rn_r1", 32'(rf[1]), 32'd9);
      chk("final_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
